// File: rtl/reg_file_2r1w_pkg.sv
// Shared types, default sizes and the byte-strobe merge for the 2R1W register file.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;

  // Upper bound on DATA_W handled by strb_merge; callers cast to/from their width.
  localparam int unsigned MAX_DATA_W = 128;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Take new bytes where the strobe is set, keep old bytes elsewhere.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_d,
    input logic [MAX_DATA_W-1:0] new_d,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_STRB_W-1:0] s;
    mask = '0;
    s    = strb;
    // Build the byte mask MSB-first by shifting, so no variable bit-selects are needed.
    for (int unsigned i = 0; i < MAX_STRB_W; i++) begin
      mask = {mask[MAX_DATA_W-9:0], {8{s[MAX_STRB_W-1]}}};
      s    = {s[MAX_STRB_W-2:0], 1'b0};
    end
    return (new_d & mask) | (old_d & ~mask);
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus between the datapath controller (master) and the register file (slave).
//   Wr*      : write request, address, data, byte strobes
//   RdEnX/RdAddrX -> RdDataX/RdValidX : read ports A and B, 1-cycle latency
//   Clr -> Busy : bulk clear start and in-progress flag
interface reg_file_2r1w_if #(
  parameter int unsigned DATA_W = reg_file_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::DEF_ADDR_W
);
  import reg_file_pkg::*;

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [STRB_W-1:0] WrStrb;
  logic              RdEnA;
  logic [ADDR_W-1:0] RdAddrA;
  logic [DATA_W-1:0] RdDataA;
  logic              RdValidA;
  logic              RdEnB;
  logic [ADDR_W-1:0] RdAddrB;
  logic [DATA_W-1:0] RdDataB;
  logic              RdValidB;
  logic              Clr;
  logic              Busy;

  modport master (
    output WrEn, WrAddr, WrData, WrStrb,
    output RdEnA, RdAddrA, RdEnB, RdAddrB, Clr,
    input  RdDataA, RdValidA, RdDataB, RdValidB, Busy
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrStrb,
    input  RdEnA, RdAddrA, RdEnB, RdAddrB, Clr,
    output RdDataA, RdValidA, RdDataB, RdValidB, Busy
  );

endinterface

// File: rtl/reg_file_2r1w_rd_port.sv
// Registered read port with write-first bypass and optional hardwired-zero entry 0.
//   rd_en/rd_addr  : read request (already gated off while a clear runs)
//   mem_data       : current contents of entry[rd_addr]
//   wr_en/wr_*     : the write committing this cycle (already qualified)
//   rd_data        : registered read data, holds when no read
//   rd_valid       : one-cycle pulse per accepted read
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  logic [DATA_W-1:0] rd_next;

  // On an address hit the read sees the post-write merged value.
  always_comb begin
    rd_next = mem_data;
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_next = DATA_W'(strb_merge(MAX_DATA_W'(mem_data), MAX_DATA_W'(wr_data),
                                   MAX_STRB_W'(wr_strb)));
    end
    if (ZERO_REG && (rd_addr == '0)) begin
      rd_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH x DATA_W register file: one byte-strobed write port, two registered read
// ports with write-first bypass, optional zero entry 0, sequenced bulk clear.
//   CLK, RST : clock and asynchronous active-low reset
//   bus      : slave side of reg_file_2r1w_if (write, read A/B, Clr/Busy)
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  reg_file_2r1w_if.slave  bus
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy;
  logic              wr_go;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              rd_valid_a, rd_valid_b;

  assign busy = (state_q == CLEAR);

  // Writes are blocked during a clear; entry 0 is read-only when hardwired to zero.
  assign wr_go = bus.WrEn && !busy && !(ZERO_REG && (bus.WrAddr == '0));

  assign wr_merged = DATA_W'(strb_merge(MAX_DATA_W'(mem[bus.WrAddr]),
                                        MAX_DATA_W'(bus.WrData),
                                        MAX_STRB_W'(bus.WrStrb)));

  // Clear FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM next state: one entry per cycle, exactly DEPTH cycles in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.Clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage: clear sequence has priority; writes are already blocked while busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem <= '{default: '0};
    end else if (busy) begin
      mem[cnt_q] <= '0;
    end else if (wr_go) begin
      mem[bus.WrAddr] <= wr_merged;
    end
  end

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_a (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en    (bus.RdEnA && !busy),
    .rd_addr  (bus.RdAddrA),
    .mem_data (mem[bus.RdAddrA]),
    .wr_en    (wr_go),
    .wr_addr  (bus.WrAddr),
    .wr_data  (bus.WrData),
    .wr_strb  (bus.WrStrb),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_b (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en    (bus.RdEnB && !busy),
    .rd_addr  (bus.RdAddrB),
    .mem_data (mem[bus.RdAddrB]),
    .wr_en    (wr_go),
    .wr_addr  (bus.WrAddr),
    .wr_data  (bus.WrData),
    .wr_strb  (bus.WrStrb),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b)
  );

  assign bus.RdDataA  = rd_data_a;
  assign bus.RdValidA = rd_valid_a;
  assign bus.RdDataB  = rd_data_b;
  assign bus.RdValidB = rd_valid_b;
  assign bus.Busy     = busy;

endmodule
